// File: rtl/noc_sequencer.sv
// Network-on-chip run sequencer: drives traffic fill, routing-table load and
// the staged two-phase network cycle loop through broadcast op codes.
module noc_sequencer #(
  parameter int ROUTER_SIZE = 16,
  parameter int ROUTER_BITS = 4,
  parameter int CYCLE_BITS  = 16,
  parameter int FILL_BITS   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CYCLE_BITS-1:0]  max_cycle,
  input  logic                   fill_pending,
  input  logic                   stall,
  output logic [3:0]             router_op,
  output logic [3:0]             traffic_op,
  output logic [ROUTER_BITS-1:0] rt_dst,
  output logic [FILL_BITS-1:0]   fill_idx,
  output logic [CYCLE_BITS-1:0]  in_cycle,
  output logic                   busy,
  output logic                   done
);

  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_PHASE0    = 4'd1;
  localparam logic [3:0] OP_PHASE1    = 4'd2;
  localparam logic [3:0] OP_LOAD_STG  = 4'd3;
  localparam logic [3:0] OP_LOAD_RT   = 4'd4;
  localparam logic [3:0] OP_INIT      = 4'd5;
  localparam logic [3:0] OP_FILL      = 4'd6;
  localparam logic [3:0] OP_DEQUEUE   = 4'd7;
  localparam logic [3:0] OP_PREDEQUE  = 4'd8;

  localparam logic [ROUTER_BITS-1:0] RT_LAST  = ROUTER_BITS'(ROUTER_SIZE - 1);
  localparam logic [FILL_BITS-1:0]   FILL_MAX = {FILL_BITS{1'b1}};
  localparam logic [CYCLE_BITS-1:0]  CYC_MAX  = {CYCLE_BITS{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_TR_INIT   = 4'd1,
    S_TR_FILL   = 4'd2,
    S_TR_PREDEQ = 4'd3,
    S_RT_INIT   = 4'd4,
    S_RT_LOAD   = 4'd5,
    S_STAGE     = 4'd6,
    S_PH0       = 4'd7,
    S_PH1       = 4'd8,
    S_DONE      = 4'd9
  } state_t;

  state_t                 state_q, state_d;
  logic [ROUTER_BITS-1:0] rt_dst_q, rt_dst_d;
  logic [FILL_BITS-1:0]   fill_idx_q, fill_idx_d;
  logic [CYCLE_BITS-1:0]  in_cycle_q, in_cycle_d;
  logic [CYCLE_BITS:0]    in_cycle_inc_s;
  logic                   last_cycle_s;

  // Extra bit keeps the termination compare exact even at in_cycle all ones.
  assign in_cycle_inc_s = {1'b0, in_cycle_q} + {{CYCLE_BITS{1'b0}}, 1'b1};
  assign last_cycle_s   = (in_cycle_inc_s == {1'b0, max_cycle});

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rt_dst_q   <= '0;
      fill_idx_q <= '0;
      in_cycle_q <= '0;
    end else begin
      state_q    <= state_d;
      rt_dst_q   <= rt_dst_d;
      fill_idx_q <= fill_idx_d;
      in_cycle_q <= in_cycle_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d    = state_q;
    rt_dst_d   = rt_dst_q;
    fill_idx_d = fill_idx_q;
    in_cycle_d = in_cycle_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_TR_INIT;
          rt_dst_d   = '0;
          fill_idx_d = '0;
          in_cycle_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_TR_INIT: state_d = S_TR_FILL;
      S_TR_FILL: begin
        if (!fill_pending) begin
          state_d = S_TR_PREDEQ;
        end else if (fill_idx_q == FILL_MAX) begin
          state_d = S_TR_PREDEQ;
        end else begin
          fill_idx_d = fill_idx_q + {{(FILL_BITS-1){1'b0}}, 1'b1};
        end
      end
      S_TR_PREDEQ: state_d = S_RT_INIT;
      S_RT_INIT: begin
        state_d  = S_RT_LOAD;
        rt_dst_d = '0;
      end
      S_RT_LOAD: begin
        if (rt_dst_q == RT_LAST) begin
          state_d = (max_cycle == '0) ? S_DONE : S_STAGE;
        end else begin
          rt_dst_d = rt_dst_q + {{(ROUTER_BITS-1){1'b0}}, 1'b1};
        end
      end
      S_STAGE: begin
        if (stall) begin
          state_d = state_q;
        end else begin
          state_d = S_PH0;
        end
      end
      S_PH0: begin
        if (stall) begin
          state_d = state_q;
        end else begin
          state_d = S_PH1;
        end
      end
      S_PH1: begin
        if (stall) begin
          state_d = state_q;
        end else begin
          in_cycle_d = (in_cycle_q == CYC_MAX) ? in_cycle_q : in_cycle_inc_s[CYCLE_BITS-1:0];
          state_d    = last_cycle_s ? S_DONE : S_STAGE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore op decode; network-cycle ops are suppressed while stalled.
  always_comb begin
    router_op  = OP_NOP;
    traffic_op = OP_NOP;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_TR_INIT:   traffic_op = OP_INIT;
      S_TR_FILL:   traffic_op = fill_pending ? OP_FILL : OP_NOP;
      S_TR_PREDEQ: traffic_op = OP_PREDEQUE;
      S_RT_INIT:   router_op  = OP_INIT;
      S_RT_LOAD:   router_op  = OP_LOAD_RT;
      S_STAGE: begin
        router_op  = stall ? OP_NOP : OP_LOAD_STG;
        traffic_op = stall ? OP_NOP : OP_DEQUEUE;
      end
      S_PH0:   router_op = stall ? OP_NOP : OP_PHASE0;
      S_PH1:   router_op = stall ? OP_NOP : OP_PHASE1;
      default: busy = 1'b0;
    endcase
  end

  assign rt_dst   = rt_dst_q;
  assign fill_idx = fill_idx_q;
  assign in_cycle = in_cycle_q;

endmodule

// File: doc/noc_sequencer.md
NOC_SEQUENCER -- requirements
Module: noc_sequencer

Interface
REQ-001 SHALL have parameter ROUTER_SIZE, default 16: number of routers and routing-table destinations.
REQ-002 SHALL have parameter ROUTER_BITS, default 4: width of rt_dst.
REQ-003 SHALL have parameter CYCLE_BITS, default 16: width of max_cycle and in_cycle.
REQ-004 SHALL have parameter FILL_BITS, default 10: width of fill_idx (1024 packets).
REQ-005 SHALL have port clk, input, 1: the single clock; one clock, all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1: begin a run; sampled only in IDLE or DONE.
REQ-008 SHALL have port max_cycle, input, CYCLE_BITS: number of simulated network cycles.
REQ-009 SHALL have port fill_pending, input, 1: at least one traffic queue still has an entry at fill_idx.
REQ-010 SHALL have port stall, input, 1: freezes the network-cycle phases.
REQ-011 SHALL have port router_op, output, 4: op code broadcast to all routers.
REQ-012 SHALL have port traffic_op, output, 4: op code broadcast to all traffic sources.
REQ-013 SHALL have port rt_dst, output, ROUTER_BITS: destination index for LoadRt.
REQ-014 SHALL have port fill_idx, output, FILL_BITS: traffic entry index for Fill.
REQ-015 SHALL have port in_cycle, output, CYCLE_BITS: completed network cycles.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE and DONE.
REQ-017 SHALL have port done, output, 1: high in DONE.

Function
REQ-018 Op encoding SHALL be NOP=0, Phase0=1, Phase1=2, LoadStaging=3, LoadRt=4, Init=5, Fill=6, Dequeue=7, PreDeque=8.
REQ-019 router_op and traffic_op SHALL be Moore-decoded from the registered state; any op not listed for a state SHALL be NOP.
REQ-020 IDLE: on start=1, go to TR_INIT and clear fill_idx, rt_dst and in_cycle to 0.
REQ-021 TR_INIT: traffic_op=Init for 1 cycle, then go to TR_FILL.
REQ-022 TR_FILL with fill_pending=1: traffic_op=Fill; fill_idx increments at the end of the cycle.
REQ-023 TR_FILL with fill_pending=0: traffic_op=NOP; go to TR_PREDEQ.
REQ-024 TR_FILL with fill_pending=1 and fill_idx at its maximum (all ones): Fill is still issued, fill_idx holds (no wrap), and the FSM goes to TR_PREDEQ.
REQ-025 TR_PREDEQ: traffic_op=PreDeque for 1 cycle, then go to RT_INIT.
REQ-026 RT_INIT: router_op=Init for 1 cycle, then go to RT_LOAD with rt_dst=0.
REQ-027 RT_LOAD: router_op=LoadRt for exactly ROUTER_SIZE cycles with rt_dst=0..ROUTER_SIZE-1, incrementing each cycle.
REQ-028 At the end of RT_LOAD, go to DONE if max_cycle==0, otherwise go to STAGE.
REQ-029 STAGE: router_op=LoadStaging and traffic_op=Dequeue; the datapath gates Dequeue per router with can_inject.
REQ-030 STAGE SHALL last 1 cycle, then go to PH0.
REQ-031 PH0: router_op=Phase0 for 1 cycle, then go to PH1.
REQ-032 PH1: router_op=Phase1; in_cycle increments at the end of the cycle.
REQ-033 At the end of PH1, go to DONE if in_cycle+1==max_cycle, otherwise go to STAGE.
REQ-034 stall=1 in STAGE/PH0/PH1: both ops NOP; state and in_cycle hold.
REQ-035 stall SHALL be ignored in all other states.
REQ-036 DONE: done=1, busy=0, both ops NOP; in_cycle, fill_idx and rt_dst hold.
REQ-037 start=1 in DONE SHALL behave as start=1 in IDLE (restart).
REQ-038 start SHALL be ignored in all other states.
REQ-039 in_cycle SHALL saturate at all ones and never wrap; runs terminate by REQ-033 before saturation.

Reset
REQ-040 rst=1 at a clock edge, in any state including mid-run, SHALL force state IDLE, router_op=NOP, traffic_op=NOP, rt_dst=0, fill_idx=0, in_cycle=0, busy=0, done=0 from the next cycle.
REQ-041 rst SHALL take priority over start and stall.

Verification
REQ-042 ROUTER_SIZE=4, max_cycle=2, fill_pending=0, start pulse -> TR_INIT, TR_FILL, TR_PREDEQ, RT_INIT, 4x LoadRt (rt_dst 0..3), 2x (LoadStaging, Phase0, Phase1); done=1 in the 15th cycle after the start edge; in_cycle=2.
REQ-043 fill_pending high for 3 cycles of TR_FILL -> exactly 3 Fill ops with fill_idx 0,1,2; fill_idx=3 on entry to TR_PREDEQ.
REQ-044 max_cycle=0 -> RT_LOAD goes directly to DONE; no LoadStaging is ever issued; in_cycle=0.
REQ-045 stall=1 for 5 cycles while in PH0 -> 5 NOP cycles, then Phase0 resumes; in_cycle is unchanged during the stall.
REQ-046 rst=1 during RT_LOAD with rt_dst=2 -> IDLE next cycle with all outputs 0; a later start reruns from TR_INIT with rt_dst restarting at 0.
REQ-047 fill_pending held at 1 -> 1024 Fill ops; fill_idx saturates at 1023; the FSM proceeds to TR_PREDEQ.
